// File: rtl/irq_latch_ctrl.sv
//==============================================================================
// Module      : irq_latch_ctrl
// Description : Set/reset pulse sequencer for an active-low NAND SR interrupt
//               flag bank, with a registered flag shadow, fixed-priority
//               arbitration and CPU request/acknowledge handshake.
//               Optional feature macro: IRQ_HALT_WAKE_EN (adds the wake output).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module irq_latch_ctrl #(
    parameter int         N_SRC     = 5,
    parameter int         PULSE_LEN = 1,
    parameter logic [7:0] VEC_BASE  = 8'h40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src_evt,
    input  logic [N_SRC-1:0] ie,
    input  logic             ime,
    input  logic             wr_en,
    input  logic [N_SRC-1:0] wr_data,
    input  logic             cpu_ack,
    output logic [N_SRC-1:0] set_n,
    output logic [N_SRC-1:0] rst_n,
    output logic [N_SRC-1:0] flags,
    output logic             irq_req,
    output logic [7:0]       irq_vec,
    output logic             busy
`ifdef IRQ_HALT_WAKE_EN
    ,
    output logic             wake
`endif
);

    localparam int         IDX_W       = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [1:0] c_PULSE_LAST = 2'(PULSE_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARB  = 2'd1,
        S_REQ  = 2'd2,
        S_CLR  = 2'd3
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [1:0]         r_clr_cnt;
    logic [N_SRC-1:0]   r_flags;
    logic [N_SRC-1:0]   r_set_n;
    logic [N_SRC-1:0]   r_rst_n;
    logic [1:0]         r_cnt [N_SRC];
    logic               r_req;
    logic [7:0]         r_vec;
    logic               r_busy;

    logic [N_SRC-1:0]   w_pend;
    logic [IDX_W-1:0]   w_arb_idx;
    logic [7:0]         w_vec;
    logic               w_abort;
    logic [N_SRC-1:0]   w_fsm_clr;
    logic [N_SRC-1:0]   w_set_cmd;
    logic [N_SRC-1:0]   w_clr_cmd;

    assign w_pend = r_flags & ie;

    // Descending scan so the lowest pending index is the last one written.
    always_comb begin
        w_arb_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_pend[i]) begin
                w_arb_idx = IDX_W'(i);
            end
        end
    end

    assign w_vec   = VEC_BASE + (8'(w_arb_idx) << 3);
    assign w_abort = !ime || !r_flags[r_idx] || !ie[r_idx];

    always_comb begin
        w_fsm_clr = '0;
        if (r_state == S_REQ && cpu_ack && !w_abort) begin
            w_fsm_clr[r_idx] = 1'b1;
        end
    end

    // A set on a bit always wins over any clear source on the same bit.
    assign w_set_cmd = src_evt | ({N_SRC{wr_en}} & wr_data);
    assign w_clr_cmd = (({N_SRC{wr_en}} & ~wr_data) | w_fsm_clr) & ~w_set_cmd;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= '0;
            r_set_n <= '1;
            r_rst_n <= '1;
            for (int i = 0; i < N_SRC; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (w_set_cmd[i]) begin
                    r_flags[i] <= 1'b1;
                    r_set_n[i] <= 1'b0;
                    r_rst_n[i] <= 1'b1;
                    r_cnt[i]   <= c_PULSE_LAST;
                end else if (w_clr_cmd[i]) begin
                    r_flags[i] <= 1'b0;
                    r_set_n[i] <= 1'b1;
                    r_rst_n[i] <= 1'b0;
                    r_cnt[i]   <= c_PULSE_LAST;
                end else if (!r_set_n[i] || !r_rst_n[i]) begin
                    if (r_cnt[i] == 2'd0) begin
                        r_set_n[i] <= 1'b1;
                        r_rst_n[i] <= 1'b1;
                    end else begin
                        r_cnt[i] <= r_cnt[i] - 2'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_clr_cnt <= '0;
            r_req     <= 1'b0;
            r_vec     <= '0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ime && |w_pend) begin
                        r_state <= S_ARB;
                        r_busy  <= 1'b1;
                    end
                end
                S_ARB: begin
                    if (|w_pend) begin
                        r_idx   <= w_arb_idx;
                        r_vec   <= w_vec;
                        r_req   <= 1'b1;
                        r_state <= S_REQ;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (w_abort) begin
                        r_req   <= 1'b0;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (cpu_ack) begin
                        r_req     <= 1'b0;
                        r_clr_cnt <= '0;
                        r_state   <= S_CLR;
                    end
                end
                S_CLR: begin
                    if (r_clr_cnt == c_PULSE_LAST) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 2'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

`ifdef IRQ_HALT_WAKE_EN
    logic r_wake;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wake <= 1'b0;
        end else begin
            r_wake <= |w_pend;
        end
    end

    assign wake = r_wake;
`endif

    assign set_n   = r_set_n;
    assign rst_n   = r_rst_n;
    assign flags   = r_flags;
    assign irq_req = r_req;
    assign irq_vec = r_vec;
    assign busy    = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_irq_latch_ctrl.sv
//==============================================================================
// Module      : tb_irq_latch_ctrl
// Description : Directed self-checking bench for irq_latch_ctrl; expected
//               vectors are queued at stimulus time and popped on irq_req.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_irq_latch_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] src_evt, ie, wr_data;
    logic       ime, wr_en, cpu_ack;
    logic [4:0] set_n, rst_n, flags;
    logic       irq_req, busy;
    logic [7:0] irq_vec;

    logic [4:0] b_wr_data;
    logic       b_wr_en;
    logic [4:0] b_set_n, b_rst_n, b_flags;
    logic       b_irq_req, b_busy;
    logic [7:0] b_irq_vec;
`ifdef IRQ_HALT_WAKE_EN
    logic       wake, b_wake;
`endif

    int         total;
    int         bad;
    logic [7:0] sb_q [$];

    irq_latch_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .src_evt (src_evt),
        .ie      (ie),
        .ime     (ime),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .cpu_ack (cpu_ack),
        .set_n   (set_n),
        .rst_n   (rst_n),
        .flags   (flags),
        .irq_req (irq_req),
        .irq_vec (irq_vec),
        .busy    (busy)
`ifdef IRQ_HALT_WAKE_EN
        ,
        .wake    (wake)
`endif
    );

    // Second instance exercises the longer pulse length.
    irq_latch_ctrl #(.PULSE_LEN(3)) dut_b (
        .clk     (clk),
        .reset   (reset),
        .src_evt (5'b00000),
        .ie      (5'b00000),
        .ime     (1'b0),
        .wr_en   (b_wr_en),
        .wr_data (b_wr_data),
        .cpu_ack (1'b0),
        .set_n   (b_set_n),
        .rst_n   (b_rst_n),
        .flags   (b_flags),
        .irq_req (b_irq_req),
        .irq_vec (b_irq_vec),
        .busy    (b_busy)
`ifdef IRQ_HALT_WAKE_EN
        ,
        .wake    (b_wake)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_vec(input string tag);
        logic [7:0] exp;
        chk({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
            exp = sb_q.pop_front();
            chk({tag, "_vec"}, 32'(irq_vec), 32'(exp));
        end
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 12 && !irq_req; i++) begin
            tick();
        end
        chk({tag, "_req_seen"}, 32'(irq_req), 1);
        if (irq_req) begin
            pop_vec(tag);
        end
    endtask

    task automatic ack_pulse();
        cpu_ack = 1'b1;
        tick();
        cpu_ack = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 12 && busy; i++) begin
            tick();
        end
        chk({tag, "_idle"}, 32'(busy), 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_flags"}, 32'(flags), 0);
        chk({tag, "_set_n"}, 32'(set_n), 32'h1F);
        chk({tag, "_rst_n"}, 32'(rst_n), 32'h1F);
        chk({tag, "_req"},   32'(irq_req), 0);
        chk({tag, "_vec0"},  32'(irq_vec), 0);
        chk({tag, "_busy"},  32'(busy), 0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        src_evt = '0; ie = '0; wr_data = '0;
        ime = 1'b0; wr_en = 1'b0; cpu_ack = 1'b0;
        b_wr_en = 1'b0; b_wr_data = '0;
        tick();
        tick();
        chk_reset_vals("rst");
        chk("rst_b_set_n", 32'(b_set_n), 32'h1F);
        reset = 1'b0;
        tick();

        // Single event on bit 2, full handshake.
        ime = 1'b1; ie = 5'h1F; src_evt = 5'b00100;
        sb_q.push_back(8'h50);
        tick();
        src_evt = '0;
        chk("t1_flags", 32'(flags), 32'h04);
        chk("t1_set_n", 32'(set_n), 32'h1B);
        chk("t1_rst_n", 32'(rst_n), 32'h1F);
        tick();
        chk("t2_busy", 32'(busy), 1);
        chk("t2_set_n", 32'(set_n), 32'h1F);
        chk("t2_req", 32'(irq_req), 0);
        tick();
        chk("t3_req", 32'(irq_req), 1);
        pop_vec("t3");
        tick();
        chk("t4_req", 32'(irq_req), 1);
        ack_pulse();
        chk("t5_flags", 32'(flags), 0);
        chk("t5_rst_n", 32'(rst_n), 32'h1B);
        chk("t5_req", 32'(irq_req), 0);
        chk("t5_busy", 32'(busy), 1);
        tick();
        chk("t6_busy", 32'(busy), 0);
        chk("t6_rst_n", 32'(rst_n), 32'h1F);

        // Two simultaneous events: bit 1 wins, bit 4 follows.
        src_evt = 5'b10010;
        sb_q.push_back(8'h48);
        sb_q.push_back(8'h60);
        tick();
        src_evt = '0;
        wait_req("p1");
        ack_pulse();
        chk("p1_flags", 32'(flags), 32'h10);
        wait_req("p2");
        ack_pulse();
        wait_idle("p2");
        chk("p2_flags", 32'(flags), 0);

        // Event on the bit being cleared in the ack cycle survives.
        src_evt = 5'b01000;
        sb_q.push_back(8'h58);
        sb_q.push_back(8'h58);
        tick();
        src_evt = '0;
        wait_req("c1");
        cpu_ack = 1'b1; src_evt = 5'b01000;
        tick();
        cpu_ack = 1'b0; src_evt = '0;
        chk("c1_flags", 32'(flags), 32'h08);
        chk("c1_rst_n", 32'(rst_n), 32'h1F);
        chk("c1_set_n", 32'(set_n), 32'h17);
        tick();
        chk("c2_rst_n", 32'(rst_n), 32'h1F);
        wait_req("c2");
        ack_pulse();
        wait_idle("c2");
        chk("c2_flags", 32'(flags), 0);

        // Abort by dropping ime during REQ.
        src_evt = 5'b00001;
        sb_q.push_back(8'h40);
        tick();
        src_evt = '0;
        wait_req("ab");
        ime = 1'b0;
        tick();
        chk("ab_req", 32'(irq_req), 0);
        chk("ab_flags", 32'(flags), 32'h01);
        chk("ab_rst_n", 32'(rst_n), 32'h1F);
        tick();
        chk("ab_busy", 32'(busy), 0);
        wr_en = 1'b1; wr_data = '0;
        tick();
        wr_en = 1'b0;
        chk("wclr_flags", 32'(flags), 0);
        chk("wclr_rst_n", 32'(rst_n), 0);
        tick();
        chk("wclr_rst_rel", 32'(rst_n), 32'h1F);
        ime = 1'b1;

        // PULSE_LEN=3 instance: set then clear two cycles later.
        b_wr_en = 1'b1; b_wr_data = 5'b00001;
        tick();
        b_wr_en = 1'b0;
        chk("pl_s1", 32'({b_set_n[0], b_rst_n[0]}), 32'b01);
        chk("pl_flag", 32'(b_flags), 32'h01);
        tick();
        chk("pl_s2", 32'({b_set_n[0], b_rst_n[0]}), 32'b01);
        b_wr_en = 1'b1; b_wr_data = 5'b00000;
        tick();
        b_wr_en = 1'b0;
        chk("pl_r1", 32'({b_set_n[0], b_rst_n[0]}), 32'b10);
        chk("pl_r1_flag", 32'(b_flags), 0);
        tick();
        chk("pl_r2", 32'({b_set_n[0], b_rst_n[0]}), 32'b10);
        tick();
        chk("pl_r3", 32'({b_set_n[0], b_rst_n[0]}), 32'b10);
        tick();
        chk("pl_rel", 32'({b_set_n[0], b_rst_n[0]}), 32'b11);

        // Reset asserted while set_n[1] pulses on both instances.
        src_evt = 5'b00010;
        b_wr_en = 1'b1; b_wr_data = 5'b00010;
        tick();
        src_evt = '0; b_wr_en = 1'b0;
        chk("mr_a_set_n", 32'(set_n), 32'h1D);
        chk("mr_b_set_n", 32'(b_set_n), 32'h1D);
        reset = 1'b1;
        tick();
        chk_reset_vals("mr");
        chk("mr_b_set_n2", 32'(b_set_n), 32'h1F);
        chk("mr_b_flags", 32'(b_flags), 0);
        reset = 1'b0;
        tick();

`ifdef IRQ_HALT_WAKE_EN
        chk("wk_rst", 32'(wake), 0);
        ime = 1'b0; ie = 5'b00001; src_evt = 5'b00001;
        tick();
        src_evt = '0;
        chk("wk_t1", 32'(wake), 0);
        tick();
        chk("wk_t2", 32'(wake), 1);
        chk("wk_req", 32'(irq_req), 0);
`endif

        chk("sb_empty", 32'(sb_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/irq_latch_ctrl.md
Name: irq_latch_ctrl

Overview:
- Sequences a bank of active-low NAND SR flag latches that hold the interrupt request flags (IF).
- Turns source event pulses and CPU IF-register writes into non-overlapping set/reset pulses on that bank, and keeps a registered shadow of the flags.
- Arbitrates pending and enabled flags by fixed priority, runs the request/acknowledge handshake with the CPU core, and clears the serviced flag on acknowledge.

Parameters:
- N_SRC, 5, number of interrupt sources. Bit 0 has the highest priority.
- PULSE_LEN, 1, cycles each set_n/rst_n pulse is held low. Legal range is 1 to 4.
- VEC_BASE, 8'h40, vector of source 0. Source i has vector VEC_BASE + 8*i.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- src_evt  in  N_SRC  one-cycle event pulses from the sources.
- ie  in  N_SRC  interrupt enable mask.
- ime  in  1  master interrupt enable.
- wr_en  in  1  CPU write strobe for the IF register.
- wr_data  in  N_SRC  IF write data: 1 sets the flag, 0 clears it.
- cpu_ack  in  1  CPU accepts the presented request.
- set_n  out  N_SRC  active-low set pulses to the latch bank.
- rst_n  out  N_SRC  active-low reset pulses to the latch bank.
- flags  out  N_SRC  registered shadow of the latch state.
- irq_req  out  1  request presented to the CPU.
- irq_vec  out  8  vector of the presented request.
- busy  out  1  high when the FSM is not IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. All outputs are registered.
- Reset values: flags=0, set_n='1, rst_n='1, irq_req=0, irq_vec=0, busy=0, FSM=IDLE, pulse counters=0.
- Reset mid-pulse: all pulses end at the edge where reset is sampled. No partial pulse remains.
- Flag set: src_evt[i] at cycle t, or a write with wr_data[i]=1, gives flags[i]=1 at t+1. set_n[i] is low for cycles t+1 .. t+PULSE_LEN.
- Flag clear: a write with wr_data[i]=0, or an FSM clear, gives flags[i]=0 at t+1. rst_n[i] is low for PULSE_LEN cycles from t+1.
- Same-bit priority: src_evt beats a write-clear and beats an FSM clear, so no event is lost.
- Pulse exclusion:
  - set_n[i] and rst_n[i] are never low in the same cycle.
  - A new command on bit i immediately replaces any pulse in progress on bit i and restarts its counter.
  - A set that repeats the current state still issues a pulse.
- FSM states:
  - IDLE: if ime and |(flags & ie), go to ARB.
  - ARB (1 cycle): latch idx = lowest set bit of (flags & ie). Go to REQ.
  - REQ:
    - irq_req=1 and irq_vec=VEC_BASE+8*idx from the first REQ cycle.
    - cpu_ack goes to CLR.
    - If ime=0, or flags[idx]=0, or ie[idx]=0, abort to IDLE. irq_req falls on the next cycle and no clear is issued.
  - CLR: at entry, irq_req=0 and flags[idx]=0 (unless src_evt[idx] occurs the same cycle). Hold rst_n[idx] low for PULSE_LEN cycles, then go to IDLE.
- Acknowledge timing: cpu_ack is ignored outside REQ. If cpu_ack and an abort condition occur in the same cycle, the abort wins.
- Priority lock: a higher-priority flag that rises during REQ does not preempt. It wins the next ARB.
- Vector arithmetic: irq_vec is 8-bit modulo 256.

Optional Feature:
- Macro: IRQ_HALT_WAKE_EN.
- Defined:
  - Adds output port wake (1 bit). wake = |(flags & ie), registered, independent of ime. Reset value is 0.
  - wake rises one cycle after the contributing flag rises.
- Undefined: the wake port and its logic are absent. All other behaviour is identical.

Test Plan:
1. Reset, ime=1, ie=5'h1F, src_evt=5'b00100 at t0 -> flags=5'b00100 and set_n[2]=0 at t1; FSM reaches REQ with irq_req=1 and irq_vec=8'h50 by t3; cpu_ack at t4 -> flags=0 and rst_n[2]=0 at t5; busy=0 at t6.
2. Events on bits 4 and 1 in the same cycle, ie=5'h1F, ime=1 -> irq_vec=8'h48 first; after ack, a second REQ presents irq_vec=8'h60.
3. In CLR for bit 3, src_evt[3] in the clear cycle -> flags[3] stays 1, rst_n[3] never goes low, and a new REQ with irq_vec=8'h58 follows.
4. In REQ, drop ime=0 -> irq_req=0 the next cycle, flags unchanged, no rst_n pulse, busy=0 two cycles later.
5. PULSE_LEN=3: write wr_data=5'b00001 then 5'b00000 two cycles later -> set_n[0] low for exactly 2 cycles, then rst_n[0] low for 3 cycles, never both low together.
6. Assert reset mid-pulse on set_n[1] -> all pulse outputs high and all outputs at reset values at the next edge. With IRQ_HALT_WAKE_EN defined: ime=0, ie[0]=1, event on bit 0 -> wake=1 while irq_req stays 0.
